muldiv_unit: RTL

Iterative 32-bit multiply/divide unit that sits beside the ALU on the register-file operand bus. It takes the same `op1`/`op2` pair the ALU receives, runs MIPS `mult`/`multu`/`div`/`divu` over multiple cycles, and holds the results in HI/LO. HI and LO feed back into the ALU's `op2` source mux for `mfhi`/`mflo`. It replaces the ALU's 16×16 multiply and combinational divide for the full-width instructions.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit MIPS mult/multu/div/divu unit holding results in HI/LO
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state;
    logic        is_div;
    logic        neg_main;
    logic        neg_rem;
    logic        zero_div;
    logic [4:0]  count;
    // Multiply: mcand is the shifted multiplicand, mplier the multiplier.
    // Divide: mcand[31:0] is the divisor, mplier the dividend/quotient, acc[32:0] the remainder.
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;

    logic        op_signed;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        fits;
    logic        calc_last;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op_signed = ~op[0];
    assign abs1      = (op_signed && op1[31]) ? (~op1 + 32'd1) : op1;
    assign abs2      = (op_signed && op2[31]) ? (~op2 + 32'd1) : op2;

    assign shifted   = {acc[31:0], mplier[31]};
    assign diff      = {1'b0, shifted} - {2'b00, mcand[31:0]};
    assign fits      = ~diff[33];

`ifdef MULDIV_EARLY_OUT_EN
    assign calc_last = (count == 5'd31) || (!is_div && (mplier[31:1] == 31'd0));
`else
    assign calc_last = (count == 5'd31);
`endif

    assign prod_fix  = neg_main ? (~acc + 64'd1) : acc;
    assign quo_fix   = neg_main ? (~mplier + 32'd1) : mplier;
    assign rem_fix   = neg_rem ? (~acc[31:0] + 32'd1) : acc[31:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            count       <= 5'd0;
            is_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
            mcand       <= 64'd0;
            mplier      <= 32'd0;
            acc         <= 64'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div      <= op[1];
                        neg_main    <= op_signed & (op1[31] ^ op2[31]);
                        neg_rem     <= op_signed & op1[31];
                        count       <= 5'd0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        acc         <= 64'd0;
                        if (op[1] && (op2 == 32'd0)) begin
                            // raw dividend is parked in mplier so FIX can return it in HI
                            zero_div <= 1'b1;
                            mplier   <= op1;
                            mcand    <= 64'd0;
                            state    <= S_FIX;
                        end else begin
                            zero_div <= 1'b0;
                            if (op[1]) begin
                                mcand  <= {32'd0, abs2};
                                mplier <= abs1;
                            end else begin
                                mcand  <= {32'd0, abs1};
                                mplier <= abs2;
                            end
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    count <= count + 5'd1;
                    if (is_div) begin
                        acc    <= {31'd0, fits ? diff[32:0] : shifted};
                        mplier <= {mplier[30:0], fits};
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                    end
                    if (calc_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (zero_div) begin
                        hi          <= mplier;
                        lo          <= 32'hFFFF_FFFF;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
